// File: rtl/apb_master_pkg.sv
// ---------------------------------------------------------------------------
// apb_master_pkg
//   Shared definitions for the two-slave APB segment: FSM state encodings,
//   default bus widths and timeout, and the wait-timer width helper.
//   Intended to be shared with later slaves and the address decoder.
// ---------------------------------------------------------------------------
package apb_master_pkg;

    // Requester FSM encodings (kept as plain constants for legacy tools)
    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_SETUP  = 2'd1;
    localparam logic [1:0] ST_ACCESS = 2'd2;

    // Default bus geometry; the slave-select bit sits just above PADDR
    localparam int DEF_ADDR_W  = 8;
    localparam int DEF_DATA_W  = 8;
    localparam int DEF_TIMEOUT = 16;

    // Wait-counter width: enough to hold TIMEOUT-1, never narrower than 1
    function automatic int timer_width(input int timeout);
        int w;
        w = $clog2(timeout + 1);
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/apb_wait_timer.sv
// ---------------------------------------------------------------------------
// apb_wait_timer
//   Counts consecutive wait-state cycles of an APB ACCESS phase and flags the
//   cycle on which the allowed budget is used up.
// Ports
//   clk      in  clock, rising edge
//   rst      in  synchronous active-high reset
//   clear    in  restart the count from 0
//   enable   in  this cycle is a wait state (slave not ready)
//   expired  out this wait state is the last one allowed; abort at this edge
// Parameter
//   TIMEOUT  wait states allowed before abort; 0 disables the timeout
// ---------------------------------------------------------------------------
module apb_wait_timer
    import apb_master_pkg::*;
#(
    parameter int TIMEOUT = DEF_TIMEOUT
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam int CNT_W = timer_width(TIMEOUT);
    // For TIMEOUT=0 this wraps to all-ones, but expired is forced low then.
    localparam logic [CNT_W-1:0] LAST = CNT_W'(TIMEOUT - 1);

    logic [CNT_W-1:0] count;

    // NOTE: sequential state uses non-blocking (<=) so every flop samples
    // the pre-edge values of the others, whatever the block order.
    always_ff @(posedge clk) begin
        if (rst) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (enable) begin
            count <= count + CNT_W'(1);
        end
    end

    // Only meaningful while waiting, so a ready slave always wins the race.
    assign expired = (TIMEOUT != 0) && enable && (count == LAST);

endmodule

// File: rtl/apb_master.sv
// ---------------------------------------------------------------------------
// apb_master
//   APB requester for a two-slave segment. Turns a valid/ready command into
//   SETUP/ACCESS transfers, decodes the slave from req_addr[ADDR_W], returns
//   read data/ready from that slave only, and aborts a wait-state stretch
//   after TIMEOUT cycles since the slaves have no PSLVERR.
// Ports
//   PCLK, PRESET            clock, synchronous active-high reset
//   req_valid/req_ready     command handshake (accepted only in IDLE)
//   req_write, req_addr,
//   req_wdata               command: direction, {slave select, PADDR}, data
//   rsp_valid               one-cycle completion pulse
//   rsp_rdata               read data on read completion, else 0
//   rsp_timeout             completion was a timeout abort
//   PSEL1/PSEL2, PENABLE,
//   PWRITE, PADDR, PWDATA   APB requester outputs
//   PRDATA1/2, PREADY1/2    APB slave responses
// ---------------------------------------------------------------------------
module apb_master
    import apb_master_pkg::*;
#(
    parameter int ADDR_W  = DEF_ADDR_W,
    parameter int DATA_W  = DEF_DATA_W,
    parameter int TIMEOUT = DEF_TIMEOUT
) (
    input  logic              PCLK,
    input  logic              PRESET,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_write,
    input  logic [ADDR_W:0]   req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              rsp_valid,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              rsp_timeout,
    output logic              PSEL1,
    output logic              PSEL2,
    output logic              PENABLE,
    output logic              PWRITE,
    output logic [ADDR_W-1:0] PADDR,
    output logic [DATA_W-1:0] PWDATA,
    input  logic [DATA_W-1:0] PRDATA1,
    input  logic [DATA_W-1:0] PRDATA2,
    input  logic              PREADY1,
    input  logic              PREADY2
);

    localparam int SEL_BIT = ADDR_W;

    logic [1:0]        state;
    logic              slave_sel;   // 0 = slave1, 1 = slave2, latched at accept
    logic              sel_ready;
    logic [DATA_W-1:0] sel_rdata;
    logic              in_access;
    logic              expired;

    // Responses from the non-addressed slave never reach the FSM.
    assign sel_ready = slave_sel ? PREADY2 : PREADY1;
    assign sel_rdata = slave_sel ? PRDATA2 : PRDATA1;
    assign in_access = (state == ST_ACCESS);
    assign req_ready = (state == ST_IDLE);

    apb_wait_timer #(
        .TIMEOUT (TIMEOUT)
    ) u_wait_timer (
        .clk     (PCLK),
        .rst     (PRESET),
        .clear   (!in_access),
        .enable  (in_access && !sel_ready),
        .expired (expired)
    );

    always_ff @(posedge PCLK) begin
        if (PRESET) begin
            state       <= ST_IDLE;
            slave_sel   <= 1'b0;
            PSEL1       <= 1'b0;
            PSEL2       <= 1'b0;
            PENABLE     <= 1'b0;
            PWRITE      <= 1'b0;
            PADDR       <= '0;
            PWDATA      <= '0;
            rsp_valid   <= 1'b0;
            rsp_rdata   <= '0;
            rsp_timeout <= 1'b0;
        end else begin
            // Completion flags are pulses; rsp_rdata holds until the next one.
            rsp_valid   <= 1'b0;
            rsp_timeout <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (req_valid) begin
                        slave_sel <= req_addr[SEL_BIT];
                        PSEL1     <= !req_addr[SEL_BIT];
                        PSEL2     <= req_addr[SEL_BIT];
                        PWRITE    <= req_write;
                        PADDR     <= req_addr[ADDR_W-1:0];
                        PWDATA    <= req_wdata;
                        state     <= ST_SETUP;
                    end
                end
                ST_SETUP: begin
                    PENABLE <= 1'b1;
                    state   <= ST_ACCESS;
                end
                ST_ACCESS: begin
                    if (sel_ready) begin
                        PSEL1     <= 1'b0;
                        PSEL2     <= 1'b0;
                        PENABLE   <= 1'b0;
                        rsp_valid <= 1'b1;
                        rsp_rdata <= PWRITE ? '0 : sel_rdata;
                        state     <= ST_IDLE;
                    end else if (expired) begin
                        PSEL1       <= 1'b0;
                        PSEL2       <= 1'b0;
                        PENABLE     <= 1'b0;
                        rsp_valid   <= 1'b1;
                        rsp_timeout <= 1'b1;
                        rsp_rdata   <= '0;
                        state       <= ST_IDLE;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
